wr_ptr_gray: RTL

- Write-side pointer and flag generator for a dual-clock FIFO; successor to the single-clock binary write pointer.
- Keeps a binary write pointer, publishes a registered Gray pointer for the read domain, and synchronises the read domain's Gray pointer internally.
- Produces full, almost-full, fill level and sticky overflow.
- Sits between the write-side producer and the dual-port RAM write port.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/gray_sync.sv | 29 ++
 rtl/wr_ptr_gray.sv | 81 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for dual-clock FIFO pointer logic: Gray conversions and depth derivation.
package fifo_pkg;

    localparam int unsigned MAX_W = 32;

    function automatic int unsigned depth_of(input int unsigned alen);
        return 32'd1 << alen;
    endfunction

    // Callers zero-extend to MAX_W and truncate the result back to their own width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Plain flop chain carrying a Gray-coded pointer across a clock domain boundary.
module gray_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/wr_ptr_gray.sv
// Write-side pointer and flag generator for a dual-clock FIFO.
module wr_ptr_gray
    import fifo_pkg::*;
#(
    parameter int unsigned ALEN        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wen,
    input  logic [ALEN:0]   i_rptr_gray,
    input  logic [ALEN:0]   i_afull_thresh,
    input  logic            i_ovf_clr,
    output logic [ALEN-1:0] o_waddr,
    output logic            o_ram_wen,
    output logic [ALEN:0]   o_wptr_gray,
    output logic            o_wfull,
    output logic            o_walmost_full,
    output logic [ALEN:0]   o_wlevel,
    output logic            o_overflow
);

    localparam int unsigned PW = ALEN + 1;

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rgray_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_pattern;
    logic [PW-1:0] level_next;

    gray_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (i_rptr_gray),
        .q    (rgray_s)
    );

    // Accept is combinational so the producer sees no extra latency.
    assign o_ram_wen = i_wen & ~o_wfull;
    assign o_waddr   = wptr_bin[ALEN-1:0];

    assign wbin_next    = wptr_bin + PW'(o_ram_wen);
    assign wgray_next   = PW'(bin2gray(MAX_W'(wbin_next)));
    assign rbin_s       = PW'(gray2bin(MAX_W'(rgray_s)));
    // Full when write Gray equals read Gray with its top two bits inverted.
    assign full_pattern = {~rgray_s[ALEN:ALEN-1], rgray_s[ALEN-2:0]};
    assign level_next   = wbin_next - rbin_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_bin       <= '0;
            o_wptr_gray    <= '0;
            o_wfull        <= 1'b0;
            o_walmost_full <= 1'b0;
            o_wlevel       <= '0;
        end else begin
            wptr_bin       <= wbin_next;
            o_wptr_gray    <= wgray_next;
            o_wfull        <= (wgray_next == full_pattern);
            o_walmost_full <= (level_next >= i_afull_thresh);
            o_wlevel       <= level_next;
        end
    end

    // Sticky overflow; a new rejected write wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overflow <= 1'b0;
        end else if (i_wen && o_wfull) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

endmodule
